ulpi_phy_responder: RTL and testbench
=====================================

# ulpi_phy_responder

PHY-side responder for the ULPI register-access and RXCMD protocol. It answers link-initiated register writes and reads on a small register file, and it injects RXCMD bytes on request. It is the counterpart of the link-side ULPI register initiator. It serves as a synthesizable PHY stand-in for loopback bring-up and as the PHY model in link-side benches.

## Interface
- `VID`, 16'h0424: vendor ID; low byte at 0x00, high byte at 0x01, read-only.
- `PID`, 16'h0009: product ID; low byte at 0x02, high byte at 0x03, read-only.
- `CLK_60M` in 1: ULPI clock; all logic on its rising edge. One clock domain.
- `NRST_A_USB` in 1: reset, synchronous, active-low.
- `ULPI_DATA_I` in 8: byte driven by the link (0x00 = NOOP).
- `ULPI_DATA_O` out 8: byte driven by the PHY; meaningful only when `ULPI_DATA_OE`=1.
- `ULPI_DATA_OE` out 1: PHY drives the bus.
- `ULPI_DIR` out 1: bus direction; 1 = PHY owns the bus.
- `ULPI_NXT` out 1: PHY accepts the current link byte.
- `ULPI_STP` in 1: link stop/abort.
- `RXCMD_REQ` in 1: level request to send an RXCMD.
- `RXCMD_VAL` in 8: RXCMD byte; captured when the request is granted.
- `RXCMD_ACK` out 1: one-cycle pulse in the cycle the RXCMD byte is on the bus.
- `FUNC_CTRL_O`, `OTG_CTRL_O` out 8: current register contents.
- `REG_WR_STB` out 1: one-cycle pulse after a committed write.
- `REG_WR_ADDR` out 6: address of the last committed write.

## Operation
- TXCMD decode in IDLE: `DATA_I[7:6]`=2'b10 is a register write and 2'b11 is a register read, with address `DATA_I[5:0]`. Opcodes 00 and 01 are ignored and the block stays in IDLE.
- Register map and reset values:
  - 0x00–0x03: VID/PID, read-only.
  - FUNC_CTRL: 0x04 write, 0x05 set, 0x06 clear; reset 0x41.
  - OTG_CTRL: 0x0A write, 0x0B set, 0x0C clear; reset 0x06.
  - SCRATCH: 0x16 write, 0x17 set, 0x18 clear; reset 0x00.
- Reads of a set or clear address return the base register.
- Unmapped addresses, including 0x2F extended: the handshake completes normally, reads return 0x00, writes are dropped with no `REG_WR_STB`.
- FUNC_CTRL bit 5 (Reset) is self-clearing: it reads 1 for exactly one cycle after commit, then 0.
- States: IDLE, CMD_ACK, WR_DATA, WR_STP, RD_TA1, RD_DATA, RX_TA1, RX_DATA, TA_BACK.
- Transitions:
  - IDLE: valid TXCMD → CMD_ACK; otherwise `RXCMD_REQ` → RX_TA1, with `RXCMD_VAL` captured.
  - CMD_ACK: `STP`=1 → IDLE (abort); write → WR_DATA; read → RD_TA1.
  - WR_DATA: latch `DATA_I` as write data. `STP`=1 → IDLE (abort); otherwise → WR_STP.
  - WR_STP: `STP`=1 → commit, → IDLE; `STP`=0 → discard, → IDLE.
  - RD_TA1 → RD_DATA → TA_BACK → IDLE.
  - RX_TA1 → RX_DATA → TA_BACK → IDLE.
- Output decode, Moore from state only, with no input-to-output combinational path:
  - `NXT`=1 in CMD_ACK and WR_DATA.
  - `DIR`=1 in RD_TA1, RD_DATA, RX_TA1, RX_DATA.
  - `DATA_OE`=1 in RD_DATA and RX_DATA.
  - `DATA_O` is the read data in RD_DATA, the captured RXCMD in RX_DATA, and 0x00 otherwise.
  - `RXCMD_ACK`=1 in RX_DATA.
- Set address: reg |= data. Clear address: reg &= ~data. Base address: reg = data.

## Timing
- Reset (`NRST_A_USB`=0 at a clock edge):
  - State → IDLE.
  - All outputs 0, except `FUNC_CTRL_O`=0x41 and `OTG_CTRL_O`=0x06.
  - SCRATCH=0x00 and `REG_WR_ADDR`=0.
  - Reset mid-transaction aborts it with no commit.
- Write, TXCMD sampled at cycle 0:
  - Cycle 1: CMD_ACK.
  - Cycle 2: WR_DATA, data sampled.
  - Cycle 3: WR_STP.
  - Register value and `REG_WR_STB` appear in cycle 4; `REG_WR_ADDR` is valid from cycle 4.
- Read, TXCMD at cycle 0:
  - Cycle 1: NXT=1.
  - Cycle 2: DIR=1, OE=0 (turnaround).
  - Cycle 3: data on the bus.
  - Cycle 4: DIR=0 (turnaround).
  - Cycle 5: IDLE, and a new TXCMD can be sampled.
- RXCMD: granted in IDLE at cycle 0; DIR=1 in cycles 1–2; byte and ACK in cycle 2; DIR=0 in cycle 3; IDLE in cycle 4.
- Simultaneous TXCMD and `RXCMD_REQ` in IDLE: the TXCMD wins. The request stays pending and is granted on the next IDLE cycle without a TXCMD.
- The link must hold the TXCMD through CMD_ACK. The byte value in CMD_ACK is not re-checked.
- Read of a register committed in the previous transaction returns the new value.

## Structure
- Package `ulpi_phy_pkg`:
  - state enum;
  - opcode constants `TXCMD_REGW`=2'b10 and `TXCMD_REGR`=2'b11;
  - address constants: FUNC_CTRL 0x04/05/06, OTG_CTRL 0x0A/0B/0C, SCRATCH 0x16/17/18, EXT_ADDR 0x2F;
  - register reset values.
- Sub-module `ulpi_phy_regfile`:
  - inputs: address, write data, commit strobe; outputs: read data, FUNC/OTG outputs;
  - holds the write/set/clear logic and the self-clearing bit.
- The top holds the FSM and the output decode.

## Test plan
- After reset: read 0x00 → `DATA_O`=0x24 in cycle 3 with `DIR`=1 and `OE`=1. Read 0x04 → 0x41.
- Write 0x16←0xAA, then read 0x16: `REG_WR_STB` at cycle 4 with `REG_WR_ADDR`=0x16, and the read returns 0xAA. Then write 0x18←0x0F → read 0x16 returns 0xA0.
- Write 0x05←0x20 (set Reset bit): FUNC_CTRL_O=0x61 for one cycle, then 0x41.
- Write to 0x16 with `STP` asserted in WR_DATA (cycle 2): no `REG_WR_STB`, SCRATCH unchanged, IDLE at cycle 3.
- `RXCMD_REQ`=1 with `RXCMD_VAL`=0x4C in the same cycle as a read TXCMD: the read completes first. RXCMD_ACK and `DATA_O`=0x4C follow two cycles after the read's return to IDLE.
- Read 0x2F and write 0x30←0x55: the read returns 0x00, the write produces no strobe, and the handshake timing is identical to mapped addresses.

Source files
------------

// File: rtl/ulpi_phy_pkg.sv
// Shared types and constants for the ULPI PHY-side register/RXCMD responder.
package ulpi_phy_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CMD_ACK,
      ST_WR_DATA,
      ST_WR_STP,
      ST_RD_TA1,
      ST_RD_DATA,
      ST_RX_TA1,
      ST_RX_DATA,
      ST_TA_BACK
   } state_t;

   typedef enum logic [1:0] {
      OP_WRITE,
      OP_SET,
      OP_CLEAR,
      OP_NONE
   } reg_op_t;

   localparam logic [1:0] TXCMD_REGW = 2'b10;
   localparam logic [1:0] TXCMD_REGR = 2'b11;

   localparam logic [5:0] ADDR_FUNC_WR  = 6'h04;
   localparam logic [5:0] ADDR_FUNC_SET = 6'h05;
   localparam logic [5:0] ADDR_FUNC_CLR = 6'h06;
   localparam logic [5:0] ADDR_OTG_WR   = 6'h0A;
   localparam logic [5:0] ADDR_OTG_SET  = 6'h0B;
   localparam logic [5:0] ADDR_OTG_CLR  = 6'h0C;
   localparam logic [5:0] ADDR_SCR_WR   = 6'h16;
   localparam logic [5:0] ADDR_SCR_SET  = 6'h17;
   localparam logic [5:0] ADDR_SCR_CLR  = 6'h18;
   localparam logic [5:0] ADDR_EXT      = 6'h2F;

   localparam logic [7:0] FUNC_CTRL_RST = 8'h41;
   localparam logic [7:0] OTG_CTRL_RST  = 8'h06;
   localparam logic [7:0] SCRATCH_RST   = 8'h00;

   localparam int FUNC_RESET_BIT = 5;

   function automatic logic [7:0] apply_op(input logic [7:0] cur, input logic [7:0] data,
                                           input reg_op_t op);
      case (op)
         OP_WRITE: return data;
         OP_SET:   return cur | data;
         OP_CLEAR: return cur & ~data;
         default:  return cur;
      endcase
   endfunction

endpackage

// File: rtl/ulpi_phy_regfile.sv
// ULPI PHY register file: ID bytes, FUNC_CTRL/OTG_CTRL/SCRATCH with write/set/clear aliases.
module ulpi_phy_regfile
   import ulpi_phy_pkg::*;
#(
   parameter logic [15:0] VID = 16'h0424,
   parameter logic [15:0] PID = 16'h0009
) (
   input  logic       clk_sys,
   input  logic       rst_b,
   input  logic [5:0] addr,
   input  logic [7:0] wdata,
   input  logic       commit,
   output logic [7:0] rdata,
   output logic       wr_hit,
   output logic [7:0] func_ctrl,
   output logic [7:0] otg_ctrl
);

   logic [7:0] scratch;
   logic       sel_func;
   logic       sel_otg;
   logic       sel_scr;
   reg_op_t    op;

   always_comb begin
      sel_func = 1'b0;
      sel_otg  = 1'b0;
      sel_scr  = 1'b0;
      op       = OP_NONE;
      rdata    = 8'h00;
      case (addr)
         6'h00:         rdata = VID[7:0];
         6'h01:         rdata = VID[15:8];
         6'h02:         rdata = PID[7:0];
         6'h03:         rdata = PID[15:8];
         ADDR_FUNC_WR:  begin sel_func = 1'b1; op = OP_WRITE; rdata = func_ctrl; end
         ADDR_FUNC_SET: begin sel_func = 1'b1; op = OP_SET;   rdata = func_ctrl; end
         ADDR_FUNC_CLR: begin sel_func = 1'b1; op = OP_CLEAR; rdata = func_ctrl; end
         ADDR_OTG_WR:   begin sel_otg  = 1'b1; op = OP_WRITE; rdata = otg_ctrl;  end
         ADDR_OTG_SET:  begin sel_otg  = 1'b1; op = OP_SET;   rdata = otg_ctrl;  end
         ADDR_OTG_CLR:  begin sel_otg  = 1'b1; op = OP_CLEAR; rdata = otg_ctrl;  end
         ADDR_SCR_WR:   begin sel_scr  = 1'b1; op = OP_WRITE; rdata = scratch;   end
         ADDR_SCR_SET:  begin sel_scr  = 1'b1; op = OP_SET;   rdata = scratch;   end
         ADDR_SCR_CLR:  begin sel_scr  = 1'b1; op = OP_CLEAR; rdata = scratch;   end
         // Extended address reads as unmapped.
         ADDR_EXT:      rdata = 8'h00;
         default:       rdata = 8'h00;
      endcase
      wr_hit = sel_func | sel_otg | sel_scr;
   end

   always_ff @(posedge clk_sys) begin
      if (!rst_b) begin
         func_ctrl <= FUNC_CTRL_RST;
         otg_ctrl  <= OTG_CTRL_RST;
         scratch   <= SCRATCH_RST;
      end else begin
         // Reset bit lives for one cycle; a commit in the same cycle overrides the clear.
         func_ctrl[FUNC_RESET_BIT] <= 1'b0;
         if (commit && sel_func) func_ctrl <= apply_op(func_ctrl, wdata, op);
         if (commit && sel_otg)  otg_ctrl  <= apply_op(otg_ctrl, wdata, op);
         if (commit && sel_scr)  scratch   <= apply_op(scratch, wdata, op);
      end
   end

endmodule

// File: rtl/ulpi_phy_responder.sv
// PHY-side ULPI responder: TXCMD register read/write handshake and RXCMD injection.
//  state      | meaning
//  IDLE       | link owns bus, waiting for TXCMD or RXCMD request
//  CMD_ACK    | NXT high, TXCMD accepted
//  WR_DATA    | NXT high, write data sampled
//  WR_STP     | waiting for STP to commit the write
//  RD_TA1     | turnaround to PHY for read data
//  RD_DATA    | read data on bus
//  RX_TA1     | turnaround to PHY for RXCMD
//  RX_DATA    | RXCMD byte on bus, ACK pulse
//  TA_BACK    | turnaround back to link
module ulpi_phy_responder
   import ulpi_phy_pkg::*;
#(
   parameter logic [15:0] VID = 16'h0424,
   parameter logic [15:0] PID = 16'h0009
) (
   input  logic       CLK_60M,
   input  logic       NRST_A_USB,
   input  logic [7:0] ULPI_DATA_I,
   output logic [7:0] ULPI_DATA_O,
   output logic       ULPI_DATA_OE,
   output logic       ULPI_DIR,
   output logic       ULPI_NXT,
   input  logic       ULPI_STP,
   input  logic       RXCMD_REQ,
   input  logic [7:0] RXCMD_VAL,
   output logic       RXCMD_ACK,
   output logic [7:0] FUNC_CTRL_O,
   output logic [7:0] OTG_CTRL_O,
   output logic       REG_WR_STB,
   output logic [5:0] REG_WR_ADDR
);

   state_t     state;
   state_t     state_nxt;
   logic [5:0] addr_q;
   logic       is_wr;
   logic [7:0] wdata_q;
   logic [7:0] rx_byte;
   logic [7:0] rd_data;
   logic       wr_hit;
   logic       commit;
   logic       txcmd_valid;

   assign txcmd_valid = (ULPI_DATA_I[7:6] == TXCMD_REGW) || (ULPI_DATA_I[7:6] == TXCMD_REGR);
   assign commit      = (state == ST_WR_STP) && ULPI_STP;

   ulpi_phy_regfile #(.VID(VID), .PID(PID)) u_regfile (
      .clk_sys   (CLK_60M),
      .rst_b     (NRST_A_USB),
      .addr      (addr_q),
      .wdata     (wdata_q),
      .commit    (commit),
      .rdata     (rd_data),
      .wr_hit    (wr_hit),
      .func_ctrl (FUNC_CTRL_O),
      .otg_ctrl  (OTG_CTRL_O)
   );

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (txcmd_valid)    state_nxt = ST_CMD_ACK;
            else if (RXCMD_REQ) state_nxt = ST_RX_TA1;
         end
         ST_CMD_ACK: begin
            if (ULPI_STP)   state_nxt = ST_IDLE;
            else if (is_wr) state_nxt = ST_WR_DATA;
            else            state_nxt = ST_RD_TA1;
         end
         ST_WR_DATA: state_nxt = ULPI_STP ? ST_IDLE : ST_WR_STP;
         ST_WR_STP:  state_nxt = ST_IDLE;
         ST_RD_TA1:  state_nxt = ST_RD_DATA;
         ST_RD_DATA: state_nxt = ST_TA_BACK;
         ST_RX_TA1:  state_nxt = ST_RX_DATA;
         ST_RX_DATA: state_nxt = ST_TA_BACK;
         ST_TA_BACK: state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   // Bus outputs are registered decodes of the next state, so they track the state register exactly.
   always_ff @(posedge CLK_60M) begin
      if (!NRST_A_USB) begin
         state        <= ST_IDLE;
         addr_q       <= 6'd0;
         is_wr        <= 1'b0;
         wdata_q      <= 8'h00;
         rx_byte      <= 8'h00;
         ULPI_DATA_O  <= 8'h00;
         ULPI_DATA_OE <= 1'b0;
         ULPI_DIR     <= 1'b0;
         ULPI_NXT     <= 1'b0;
         RXCMD_ACK    <= 1'b0;
         REG_WR_STB   <= 1'b0;
         REG_WR_ADDR  <= 6'd0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && txcmd_valid) begin
            addr_q <= ULPI_DATA_I[5:0];
            is_wr  <= (ULPI_DATA_I[7:6] == TXCMD_REGW);
         end else if (state == ST_IDLE && RXCMD_REQ) begin
            rx_byte <= RXCMD_VAL;
         end
         if (state == ST_WR_DATA) wdata_q <= ULPI_DATA_I;
         REG_WR_STB <= commit && wr_hit;
         if (commit && wr_hit) REG_WR_ADDR <= addr_q;
         ULPI_NXT     <= (state_nxt == ST_CMD_ACK) || (state_nxt == ST_WR_DATA);
         ULPI_DIR     <= (state_nxt == ST_RD_TA1) || (state_nxt == ST_RD_DATA) ||
                         (state_nxt == ST_RX_TA1) || (state_nxt == ST_RX_DATA);
         ULPI_DATA_OE <= (state_nxt == ST_RD_DATA) || (state_nxt == ST_RX_DATA);
         RXCMD_ACK    <= (state_nxt == ST_RX_DATA);
         if (state_nxt == ST_RD_DATA)      ULPI_DATA_O <= rd_data;
         else if (state_nxt == ST_RX_DATA) ULPI_DATA_O <= rx_byte;
         else                              ULPI_DATA_O <= 8'h00;
      end
   end

endmodule

// File: tb/tb_ulpi_phy_responder.sv
// Scoreboard bench for ulpi_phy_responder: stimulus pushes expected bus bytes and write strobes.
module tb_ulpi_phy_responder;

   logic       CLK_60M = 1'b0;
   logic       NRST_A_USB = 1'b0;
   logic [7:0] ULPI_DATA_I = 8'h00;
   logic       ULPI_STP = 1'b0;
   logic       RXCMD_REQ = 1'b0;
   logic [7:0] RXCMD_VAL = 8'h00;
   logic [7:0] ULPI_DATA_O;
   logic       ULPI_DATA_OE;
   logic       ULPI_DIR;
   logic       ULPI_NXT;
   logic       RXCMD_ACK;
   logic [7:0] FUNC_CTRL_O;
   logic [7:0] OTG_CTRL_O;
   logic       REG_WR_STB;
   logic [5:0] REG_WR_ADDR;

   ulpi_phy_responder dut (
      .CLK_60M      (CLK_60M),
      .NRST_A_USB   (NRST_A_USB),
      .ULPI_DATA_I  (ULPI_DATA_I),
      .ULPI_DATA_O  (ULPI_DATA_O),
      .ULPI_DATA_OE (ULPI_DATA_OE),
      .ULPI_DIR     (ULPI_DIR),
      .ULPI_NXT     (ULPI_NXT),
      .ULPI_STP     (ULPI_STP),
      .RXCMD_REQ    (RXCMD_REQ),
      .RXCMD_VAL    (RXCMD_VAL),
      .RXCMD_ACK    (RXCMD_ACK),
      .FUNC_CTRL_O  (FUNC_CTRL_O),
      .OTG_CTRL_O   (OTG_CTRL_O),
      .REG_WR_STB   (REG_WR_STB),
      .REG_WR_ADDR  (REG_WR_ADDR)
   );

   always #5 CLK_60M = ~CLK_60M;

   typedef struct {
      logic [7:0] val;
      int         at;
      logic       rx;
   } exp_data_t;

   typedef struct {
      logic [5:0] addr;
      int         at;
   } exp_stb_t;

   exp_data_t exp_data[$];
   exp_stb_t  exp_stb[$];
   exp_data_t md;
   exp_stb_t  ms;
   int cyc = 0;
   int checks = 0;
   int errors = 0;

   always @(posedge CLK_60M) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: pops an expectation whenever the DUT drives a byte or strobes a write.
   always @(negedge CLK_60M) begin
      if (ULPI_DATA_OE === 1'b1) begin
         if (exp_data.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_bus_byte: got 0x%0h at cycle %0d, none expected", ULPI_DATA_O, cyc);
         end else begin
            md = exp_data.pop_front();
            chk("bus_byte", 32'(ULPI_DATA_O), 32'(md.val));
            chk("bus_cycle", cyc, md.at);
            chk("bus_dir", 32'(ULPI_DIR), 32'd1);
            chk("rxcmd_ack", 32'(RXCMD_ACK), 32'(md.rx));
         end
      end else if (RXCMD_ACK !== 1'b0) begin
         checks++;
         errors++;
         $display("FAIL ack_without_oe: got ack=%b oe=%b at cycle %0d", RXCMD_ACK, ULPI_DATA_OE, cyc);
      end
      if (REG_WR_STB !== 1'b0) begin
         if (exp_stb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_wr_stb: got addr 0x%0h at cycle %0d, none expected", REG_WR_ADDR, cyc);
         end else begin
            ms = exp_stb.pop_front();
            chk("wr_stb_addr", 32'(REG_WR_ADDR), 32'(ms.addr));
            chk("wr_stb_cycle", cyc, ms.at);
         end
      end
   end

   task automatic do_read(input logic [5:0] addr, input logic [7:0] exp_val, input bit with_rx);
      int t0;
      @(negedge CLK_60M);
      ULPI_DATA_I = {2'b11, addr};
      t0 = cyc;
      exp_data.push_back('{exp_val, t0 + 3, 1'b0});
      if (with_rx) begin
         RXCMD_REQ = 1'b1;
         RXCMD_VAL = 8'h4C;
         exp_data.push_back('{8'h4C, t0 + 7, 1'b1});
      end
      @(negedge CLK_60M);
      chk("rd_nxt_c1", 32'(ULPI_NXT), 32'd1);
      chk("rd_dir_c1", 32'(ULPI_DIR), 32'd0);
      @(negedge CLK_60M);
      ULPI_DATA_I = 8'h00;
      chk("rd_dir_c2", 32'(ULPI_DIR), 32'd1);
      chk("rd_oe_c2", 32'(ULPI_DATA_OE), 32'd0);
      @(negedge CLK_60M);
      @(negedge CLK_60M);
      chk("rd_dir_c4", 32'(ULPI_DIR), 32'd0);
      chk("rd_oe_c4", 32'(ULPI_DATA_OE), 32'd0);
   endtask

   // mode 0: commit with STP in WR_STP; 1: abort with STP in WR_DATA; 2: no STP, discard
   task automatic do_write(input logic [5:0] addr, input logic [7:0] data, input int mode,
                           input bit mapped);
      int t0;
      @(negedge CLK_60M);
      ULPI_DATA_I = {2'b10, addr};
      t0 = cyc;
      if (mode == 0 && mapped) exp_stb.push_back('{addr, t0 + 4});
      @(negedge CLK_60M);
      chk("wr_nxt_c1", 32'(ULPI_NXT), 32'd1);
      chk("wr_dir_c1", 32'(ULPI_DIR), 32'd0);
      @(negedge CLK_60M);
      chk("wr_nxt_c2", 32'(ULPI_NXT), 32'd1);
      ULPI_DATA_I = data;
      ULPI_STP = (mode == 1);
      @(negedge CLK_60M);
      chk("wr_nxt_c3", 32'(ULPI_NXT), 32'd0);
      chk("wr_dir_c3", 32'(ULPI_DIR), 32'd0);
      ULPI_DATA_I = 8'h00;
      ULPI_STP = (mode == 0);
      @(negedge CLK_60M);
      ULPI_STP = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge CLK_60M);
      chk("rst_func", 32'(FUNC_CTRL_O), 'h41);
      chk("rst_otg", 32'(OTG_CTRL_O), 'h06);
      chk("rst_dir", 32'(ULPI_DIR), 0);
      chk("rst_nxt", 32'(ULPI_NXT), 0);
      chk("rst_oe", 32'(ULPI_DATA_OE), 0);
      chk("rst_data", 32'(ULPI_DATA_O), 0);
      chk("rst_ack", 32'(RXCMD_ACK), 0);
      chk("rst_stb", 32'(REG_WR_STB), 0);
      chk("rst_wr_addr", 32'(REG_WR_ADDR), 0);
      NRST_A_USB = 1'b1;

      do_read(6'h00, 8'h24, 0);
      do_read(6'h01, 8'h04, 0);
      do_read(6'h02, 8'h09, 0);
      do_read(6'h03, 8'h00, 0);
      do_read(6'h04, 8'h41, 0);
      do_read(6'h0C, 8'h06, 0);

      do_write(6'h16, 8'hAA, 0, 1);
      do_read(6'h16, 8'hAA, 0);
      chk("last_wr_addr_16", 32'(REG_WR_ADDR), 'h16);
      do_write(6'h18, 8'h0F, 0, 1);
      do_read(6'h16, 8'hA0, 0);
      do_read(6'h17, 8'hA0, 0);

      do_write(6'h05, 8'h20, 0, 1);
      chk("func_reset_bit_set", 32'(FUNC_CTRL_O), 'h61);
      @(negedge CLK_60M);
      chk("func_reset_bit_clr", 32'(FUNC_CTRL_O), 'h41);

      do_write(6'h16, 8'h33, 1, 1);
      do_read(6'h16, 8'hA0, 0);
      do_write(6'h16, 8'h33, 2, 1);
      do_read(6'h16, 8'hA0, 0);

      do_write(6'h0B, 8'hF0, 0, 1);
      do_read(6'h0A, 8'hF6, 0);
      chk("otg_out", 32'(OTG_CTRL_O), 'hF6);
      do_write(6'h06, 8'h01, 0, 1);
      chk("func_clear", 32'(FUNC_CTRL_O), 'h40);

      do_read(6'h04, 8'h40, 1);
      begin
         int waited = 0;
         while (RXCMD_ACK !== 1'b1 && waited < 12) begin
            @(negedge CLK_60M);
            waited++;
         end
         chk("rxcmd_ack_seen", 32'(RXCMD_ACK), 1);
      end
      RXCMD_REQ = 1'b0;
      repeat (3) @(negedge CLK_60M);
      chk("rx_done_dir", 32'(ULPI_DIR), 0);

      do_read(6'h2F, 8'h00, 0);
      do_write(6'h30, 8'h55, 0, 0);
      do_read(6'h30, 8'h00, 0);
      chk("wr_addr_kept", 32'(REG_WR_ADDR), 'h06);

      @(negedge CLK_60M);
      ULPI_DATA_I = 8'h96;
      @(negedge CLK_60M);
      @(negedge CLK_60M);
      ULPI_DATA_I = 8'h77;
      @(negedge CLK_60M);
      ULPI_DATA_I = 8'h00;
      ULPI_STP = 1'b1;
      NRST_A_USB = 1'b0;
      @(negedge CLK_60M);
      ULPI_STP = 1'b0;
      NRST_A_USB = 1'b1;
      chk("midrst_func", 32'(FUNC_CTRL_O), 'h41);
      chk("midrst_otg", 32'(OTG_CTRL_O), 'h06);
      chk("midrst_wr_addr", 32'(REG_WR_ADDR), 0);
      do_read(6'h16, 8'h00, 0);

      repeat (4) @(negedge CLK_60M);
      chk("data_queue_empty", exp_data.size(), 0);
      chk("stb_queue_empty", exp_stb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
      $fatal(1);
   end

endmodule
